game_tick_ctrl: RTL and testbench
=================================

# game_tick_ctrl

Game-speed controller and tick scheduler for the volcano game. It sequences a game session through idle, run, pause and over states. While running, it emits a single-cycle `tick` enable at a period set by the difficulty level latched at start, and it counts elapsed ticks. Game logic (player movement, eruption updates, drawing) advances only on `tick`, so game speed is decided entirely in this block.

## Interface
Parameters:
- `CNT_W`, 23: width of the period counter and period register.
- `DIV_NORMAL`, 2_500_000: tick period in clk cycles, normal level.
- `DIV_HARD`, 1_250_000: tick period in clk cycles, difficult level.
- `DIV_MIN`, 625_000: floor on the period under speed-up; must be ≥2.
- `SPEEDUP_TICKS`, 64: ticks between speed-up steps.
- `SPEEDUP_STEP`, 125_000: period decrement per speed-up step.

Ports:
- `clk`  in  1  system clock; the single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begins a session from IDLE or OVER.
- `pause_req`  in  1  one-cycle pulse; toggles RUN↔PAUSE.
- `game_over`  in  1  one-cycle pulse; ends the session.
- `game_level`  in  1  0 = normal, 1 = difficult; sampled only on an accepted `start`.
- `tick`  out  1  one-cycle game-advance strobe.
- `state`  out  2  IDLE=0, RUN=1, PAUSE=2, OVER=3.
- `level`  out  1  latched `game_level`.
- `tick_count`  out  16  ticks issued this session; saturates at 16'hFFFF.
- `speed_stage`  out  4  number of applied speed-up steps; saturates at 15.

## Operation
- Reset values: `state`=IDLE, `tick`=0, `level`=0, `tick_count`=0, `speed_stage`=0. The internal counter is 0 and the period register is `DIV_NORMAL`.
- IDLE or OVER, `start`=1: go to RUN.
  - `level` ← `game_level`.
  - Period ← `DIV_HARD` if `level`=1, else `DIV_NORMAL`.
  - Counter, `tick_count` and `speed_stage` ← 0.
- RUN: the counter increments each cycle. When the counter equals period−1:
  - Counter ← 0.
  - `tick` ← 1 for one cycle.
  - `tick_count` ← `tick_count`+1, saturating.
- RUN, `pause_req`: go to PAUSE. The counter freezes at its current value.
- PAUSE, `pause_req`: go to RUN. Counting resumes from the frozen value.
- RUN or PAUSE, `game_over`: go to OVER. The counter is held; `tick_count` and `level` are held for display.
- Priority within a cycle: `game_over` > `pause_req` > tick generation.
  - If a transition is taken in the cycle where the counter equals period−1, no tick is issued that cycle.
  - Under `pause_req`, the counter stays at period−1, so the tick fires on the first RUN cycle after resume.
- `start` is ignored in RUN and PAUSE.
- `pause_req` is ignored in IDLE and OVER.
- `game_level` changes outside an accepted `start` have no effect.
- `tick` is never asserted outside RUN.
- `reset` mid-session forces all reset values on the next edge and overrides every other input.

## Timing
- `tick` is registered.
  - The first tick is high in the cycle exactly *period* cycles after the edge that samples `start`.
  - Subsequent ticks are spaced exactly *period* cycles apart while in RUN.
- Paused cycles do not count toward the period. The total number of RUN cycles between ticks always equals the period.
- `state` updates on the edge that samples the causing pulse (latency 1).
- `tick_count` updates on the same edge that raises `tick`.
- All arithmetic is unsigned at `CNT_W`. Periods must satisfy `DIV_MIN` ≤ `DIV_HARD` ≤ `DIV_NORMAL` < 2^`CNT_W`.

## Configuration
- `GAME_SPEEDUP_EN` defined:
  - On the tick edge where `tick_count`+1 is a nonzero multiple of `SPEEDUP_TICKS`, period ← max(period−`SPEEDUP_STEP`, `DIV_MIN`).
  - The new period applies from the next interval.
  - `speed_stage` increments, saturating, only when the period actually decreases.
- `GAME_SPEEDUP_EN` undefined:
  - The period stays constant for the whole session.
  - `speed_stage` is tied to 0.
  - No speed-up logic is synthesized.

## Test plan
All tests use `DIV_NORMAL`=10, `DIV_HARD`=5, `DIV_MIN`=3, `SPEEDUP_TICKS`=4, `SPEEDUP_STEP`=2.
- Reset: assert `reset` for 2 cycles with `start` held high → `state`=0, `tick`=0, `tick_count`=0, `level`=0 throughout.
- Normal run: `start` with `game_level`=0 → first `tick` 10 cycles after the start edge, then every 10 cycles; `tick_count`=5 after 50 cycles.
- Difficult run: `start` with `game_level`=1, then toggle `game_level` during RUN → `level`=1, `tick` every 5 cycles unchanged.
- Pause: pulse `pause_req` with the counter at 3, wait 20 cycles, pulse `pause_req` → no tick in PAUSE; next tick 7 cycles after resume.
- Priority and restart: `game_over` and `pause_req` in the same cycle → `state`=3; `tick_count` held. Then `start` → RUN with `tick_count`=0, first tick 10 cycles later.
- Speed-up (`GAME_SPEEDUP_EN` defined), normal level → tick intervals 10×4, 8×4, 6×4, 4×4, then 3 forever; `speed_stage` ends at 4. Macro undefined → 10 forever, `speed_stage`=0.

Source files
------------

// File: rtl/game_tick_ctrl.sv
// game_tick_ctrl: session FSM and game-speed tick scheduler for the volcano game.
// It steps through IDLE / RUN / PAUSE / OVER. While in RUN it issues a
// one-cycle `tick` every `period` RUN cycles and counts the ticks issued.
// Optional feature macro: GAME_SPEEDUP_EN. When it is defined, the tick
// period shrinks by SPEEDUP_STEP every SPEEDUP_TICKS ticks, and it never goes
// below DIV_MIN.
module game_tick_ctrl #(
    parameter int CNT_W         = 23,
    parameter int DIV_NORMAL    = 2_500_000,
    parameter int DIV_HARD      = 1_250_000,
    parameter int DIV_MIN       = 625_000,
    parameter int SPEEDUP_TICKS = 64,
    parameter int SPEEDUP_STEP  = 125_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        pause_req,
    input  logic        game_over,
    input  logic        game_level,
    output logic        tick,
    output logic [1:0]  state,
    output logic        level,
    output logic [15:0] tick_count,
    output logic [3:0]  speed_stage
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        OVER  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] P_NORMAL = CNT_W'(DIV_NORMAL);
    localparam logic [CNT_W-1:0] P_HARD   = CNT_W'(DIV_HARD);

    // A bad parameter set stops elaboration. Without this check the counter
    // compare could wrap and never fire.
    if (DIV_MIN < 2 || DIV_HARD < DIV_MIN || DIV_NORMAL < DIV_HARD ||
        SPEEDUP_TICKS < 1 || SPEEDUP_STEP < 1) begin : g_bad_cfg
        $error("game_tick_ctrl: inconsistent period parameters");
    end

    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic             at_end;
    logic [15:0]      tc_inc;

    assign state  = st;
    assign at_end = (cnt == period - CNT_W'(1));
    assign tc_inc = (tick_count == 16'hFFFF) ? tick_count : tick_count + 16'd1;

`ifdef GAME_SPEEDUP_EN
    localparam logic [CNT_W-1:0] P_MIN   = CNT_W'(DIV_MIN);
    localparam logic [CNT_W-1:0] P_STEP  = CNT_W'(SPEEDUP_STEP);
    localparam logic [CNT_W:0]   P_FLOOR = (CNT_W+1)'(DIV_MIN) + (CNT_W+1)'(SPEEDUP_STEP);

    logic [16:0]      tc_plus1;
    logic             step_due;
    logic [CNT_W-1:0] next_period;
    logic [3:0]       stage_q;

    // A step is due on each tick that ends a group of SPEEDUP_TICKS ticks.
    // Once the count saturates, the wrap to zero is not a multiple, so no step.
    assign tc_plus1    = {1'b0, tick_count} + 17'd1;
    assign step_due    = (tick_count != 16'hFFFF) &&
                         ((tc_plus1 % 17'(SPEEDUP_TICKS)) == 17'd0);
    assign next_period = ({1'b0, period} >= P_FLOOR) ? (period - P_STEP) : P_MIN;
    assign speed_stage = stage_q;
`else
    assign speed_stage = 4'd0;
`endif

    // Session FSM, period counter and tick/tick_count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            tick       <= 1'b0;
            level      <= 1'b0;
            tick_count <= 16'd0;
            cnt        <= '0;
            period     <= P_NORMAL;
`ifdef GAME_SPEEDUP_EN
            stage_q    <= 4'd0;
`endif
        end else begin
            tick <= 1'b0;
            case (st)
                IDLE, OVER: begin
                    if (start) begin
                        st         <= RUN;
                        level      <= game_level;
                        period     <= game_level ? P_HARD : P_NORMAL;
                        cnt        <= '0;
                        tick_count <= 16'd0;
`ifdef GAME_SPEEDUP_EN
                        stage_q    <= 4'd0;
`endif
                    end
                end
                RUN: begin
                    // A transition takes priority. The counter freezes, even at
                    // period-1, so a pending tick fires right after resume.
                    if (game_over) begin
                        st <= OVER;
                    end else if (pause_req) begin
                        st <= PAUSE;
                    end else if (at_end) begin
                        cnt        <= '0;
                        tick       <= 1'b1;
                        tick_count <= tc_inc;
`ifdef GAME_SPEEDUP_EN
                        if (step_due && (next_period < period)) begin
                            period <= next_period;
                            if (stage_q != 4'hF)
                                stage_q <= stage_q + 4'd1;
                        end
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                PAUSE: begin
                    if (game_over)
                        st <= OVER;
                    else if (pause_req)
                        st <= RUN;
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_tick_ctrl.sv
// tb_game_tick_ctrl: testbench for game_tick_ctrl. It applies a table of
// directed vectors, then hand-written sequences for pause, priority and
// speed-up timing. Build it with or without GAME_SPEEDUP_EN.
module tb_game_tick_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        pause_req = 1'b0;
    logic        game_over = 1'b0;
    logic        game_level = 1'b0;
    logic        tick;
    logic [1:0]  state;
    logic        level;
    logic [15:0] tick_count;
    logic [3:0]  speed_stage;

    int checks = 0;
    int failures = 0;

    game_tick_ctrl #(
        .CNT_W(23), .DIV_NORMAL(10), .DIV_HARD(5), .DIV_MIN(3),
        .SPEEDUP_TICKS(4), .SPEEDUP_STEP(2)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pause_req(pause_req),
        .game_over(game_over), .game_level(game_level), .tick(tick),
        .state(state), .level(level), .tick_count(tick_count),
        .speed_stage(speed_stage)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, st, pr, go, lvl;
        int          wait_cyc;
        logic [1:0]  e_state;
        logic        e_tick;
        logic        e_level;
        logic [15:0] e_tc;
    } vec_t;

    vec_t vecs[21];

    // Advance one edge; outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic pulse_start(input logic lvl);
        game_level = lvl;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_pause();
        pause_req = 1'b1;
        cyc();
        pause_req = 1'b0;
    endtask

    // Count the edges until tick is seen. The result is 99 if no tick appears
    // within the bound.
    task automatic wait_tick(output int n);
        n = 99;
        for (int c = 1; c <= 40; c++) begin
            cyc();
            if (tick === 1'b1) begin
                n = c;
                break;
            end
        end
    endtask

    function automatic int exp_iv(input int k);
`ifdef GAME_SPEEDUP_EN
        case (k / 4)
            0: return 10;
            1: return 8;
            2: return 6;
            3: return 4;
            default: return 3;
        endcase
`else
        return 10 + 0 * k;
`endif
    endfunction

    initial begin
        int n;
        int bad;
        // rst st pr go lvl wait | state tick level tc
        vecs[0]  = '{1'b1,1'b1,1'b0,1'b0,1'b0, 0, 2'd0,1'b0,1'b0,16'd0};
        vecs[1]  = '{1'b1,1'b1,1'b0,1'b0,1'b1, 0, 2'd0,1'b0,1'b0,16'd0};
        vecs[2]  = '{1'b0,1'b1,1'b0,1'b0,1'b0, 0, 2'd1,1'b0,1'b0,16'd0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 8, 2'd1,1'b0,1'b0,16'd0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 0, 2'd1,1'b1,1'b0,16'd1};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,1'b0, 0, 2'd1,1'b0,1'b0,16'd1};
        vecs[6]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,18, 2'd1,1'b1,1'b0,16'd3};
        vecs[7]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 0, 2'd2,1'b0,1'b0,16'd3};
        vecs[8]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,19, 2'd2,1'b0,1'b0,16'd3};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b0,1'b0, 0, 2'd1,1'b0,1'b0,16'd3};
        vecs[10] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 9, 2'd1,1'b1,1'b0,16'd4};
        vecs[11] = '{1'b0,1'b0,1'b1,1'b1,1'b0, 0, 2'd3,1'b0,1'b0,16'd4};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 5, 2'd3,1'b0,1'b0,16'd4};
        vecs[13] = '{1'b0,1'b0,1'b1,1'b0,1'b0, 0, 2'd3,1'b0,1'b0,16'd4};
        vecs[14] = '{1'b0,1'b1,1'b0,1'b0,1'b1, 0, 2'd1,1'b0,1'b1,16'd0};
        vecs[15] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3, 2'd1,1'b0,1'b1,16'd0};
        vecs[16] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 0, 2'd1,1'b1,1'b1,16'd1};
        vecs[17] = '{1'b0,1'b0,1'b0,1'b0,1'b1, 4, 2'd1,1'b1,1'b1,16'd2};
        vecs[18] = '{1'b0,1'b1,1'b0,1'b0,1'b0, 0, 2'd1,1'b0,1'b1,16'd2};
        vecs[19] = '{1'b0,1'b0,1'b0,1'b0,1'b0, 3, 2'd1,1'b1,1'b1,16'd3};
        vecs[20] = '{1'b1,1'b0,1'b0,1'b0,1'b1, 0, 2'd0,1'b0,1'b0,16'd0};

        #1;
        for (int i = 0; i < 21; i++) begin
            reset      = vecs[i].rst;
            start      = vecs[i].st;
            pause_req  = vecs[i].pr;
            game_over  = vecs[i].go;
            game_level = vecs[i].lvl;
            cyc();
            reset = 1'b0; start = 1'b0; pause_req = 1'b0; game_over = 1'b0;
            for (int w = 0; w < vecs[i].wait_cyc; w++) cyc();
            chk($sformatf("vec%0d state", i), 32'(state), 32'(vecs[i].e_state));
            chk($sformatf("vec%0d tick", i), 32'(tick), 32'(vecs[i].e_tick));
            chk($sformatf("vec%0d level", i), 32'(level), 32'(vecs[i].e_level));
            chk($sformatf("vec%0d tick_count", i), 32'(tick_count), 32'(vecs[i].e_tc));
        end
        chk("reset speed_stage", 32'(speed_stage), 32'd0);

        // Pause with the counter at 3: no tick while paused, then 7 cycles to the tick.
        do_reset();
        pulse_start(1'b0);
        repeat (3) cyc();
        pulse_pause();
        chk("pause3 state", 32'(state), 32'd2);
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            cyc();
            if (tick !== 1'b0 || state !== 2'd2) bad++;
        end
        chk("pause3 quiet cycles", 32'(bad), 32'd0);
        pulse_pause();
        chk("pause3 resume state", 32'(state), 32'd1);
        wait_tick(n);
        chk("pause3 resume-to-tick", 32'(n), 32'd7);

        // Pause on the period-1 cycle: that tick is suppressed and fires right after resume.
        do_reset();
        pulse_start(1'b0);
        repeat (9) cyc();
        pulse_pause();
        chk("pause_end tick suppressed", 32'(tick), 32'd0);
        chk("pause_end state", 32'(state), 32'd2);
        pulse_pause();
        chk("pause_end resume tick", 32'(tick), 32'd0);
        cyc();
        chk("pause_end first run tick", 32'(tick), 32'd1);
        chk("pause_end tick_count", 32'(tick_count), 32'd1);

        // Restart after game over: first tick comes 10 cycles after the start edge.
        game_over = 1'b1;
        pause_req = 1'b1;
        cyc();
        game_over = 1'b0;
        pause_req = 1'b0;
        chk("over state", 32'(state), 32'd3);
        pulse_start(1'b0);
        chk("restart tick_count", 32'(tick_count), 32'd0);
        wait_tick(n);
        chk("restart first tick", 32'(n), 32'd10);

        // Tick intervals over 20 ticks: they shrink with speed-up, otherwise stay at 10.
        do_reset();
        pulse_start(1'b0);
        for (int k = 0; k < 20; k++) begin
            wait_tick(n);
            chk($sformatf("interval%0d", k), 32'(n), 32'(exp_iv(k)));
        end
        chk("speed tick_count", 32'(tick_count), 32'd20);
`ifdef GAME_SPEEDUP_EN
        chk("speed_stage final", 32'(speed_stage), 32'd4);
`else
        chk("speed_stage final", 32'(speed_stage), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Time limit for the whole run.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
